// File: rtl/ramp_pkg.sv
// Shared constants, state encoding and helpers for the ramp player datapath.
package ramp_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int RATE_WIDTH_DEF = 16;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_PLAY = 1'b1;

    // A programmed period of 0 behaves as 1 so the player never stalls.
    function automatic logic [31:0] rate_clamp(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

endpackage

// File: rtl/axis_ramp_fifo.sv
// Synchronous sample FIFO with a combinational head and registered occupancy.
module axis_ramp_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push, do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/axis_ramp_player.sv
// Replays buffered AXI-Stream ramp samples to a DAC, one sample every cfg_rate cycles.
// The FIFO lives in a sub-module; this file holds only the pacing FSM and counters.
module axis_ramp_player
    import ramp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int RATE_WIDTH = RATE_WIDTH_DEF
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [RATE_WIDTH-1:0] cfg_rate,
    input  logic [RATE_WIDTH-1:0] cfg_len,
    input  logic                  ramp_rq,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] dac_data,
    output logic                  dac_strb,
    output logic                  busy,
    output logic                  underflow,
    output logic [RATE_WIDTH-1:0] sample_cnt
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [RATE_WIDTH-1:0] RATE_ONE = RATE_WIDTH'(1);

    logic                  fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  push, pop, tick, start;

    state_t                state_reg;
    logic                  ready_reg, dac_strb_reg, underflow_reg;
    logic [RATE_WIDTH-1:0] rate_reg, rate_cnt_reg, remaining_reg, sample_cnt_reg;
    logic [DATA_WIDTH-1:0] dac_data_reg;

    // ready_reg keeps tready low until the first edge after reset release.
    assign s_axis_tready = ready_reg && !fifo_full;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign tick          = (state_reg == ST_PLAY) && (rate_cnt_reg == '0);
    assign pop           = tick && (fifo_count != '0);
    assign start         = (state_reg == ST_IDLE) && ramp_rq && (cfg_len != '0);

    assign dac_data   = dac_data_reg;
    assign dac_strb   = dac_strb_reg;
    assign busy       = (state_reg == ST_PLAY);
    assign underflow  = underflow_reg;
    assign sample_cnt = sample_cnt_reg;

    axis_ramp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (push),
        .pop     (pop),
        .din     (s_axis_tdata),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg      <= ST_IDLE;
            ready_reg      <= 1'b0;
            dac_strb_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
            rate_reg       <= '0;
            rate_cnt_reg   <= '0;
            remaining_reg  <= '0;
            sample_cnt_reg <= '0;
            dac_data_reg   <= '0;
        end else begin
            ready_reg    <= 1'b1;
            dac_strb_reg <= pop;
            if (start) begin
                state_reg      <= ST_PLAY;
                rate_reg       <= RATE_WIDTH'(rate_clamp(32'(cfg_rate)));
                remaining_reg  <= cfg_len;
                sample_cnt_reg <= '0;
                underflow_reg  <= 1'b0;
                rate_cnt_reg   <= '0;
            end else if (state_reg == ST_PLAY) begin
                // The counter free-runs on the latched period; a missed tick is retried next period.
                rate_cnt_reg <= tick ? (rate_reg - RATE_ONE) : (rate_cnt_reg - RATE_ONE);
                if (pop) begin
                    dac_data_reg   <= fifo_head;
                    sample_cnt_reg <= sample_cnt_reg + RATE_ONE;
                    remaining_reg  <= remaining_reg - RATE_ONE;
                    if (remaining_reg == RATE_ONE) begin
                        state_reg <= ST_IDLE;
                    end
                end else if (tick && fifo_empty) begin
                    underflow_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_ramp_player.sv
// Scoreboard bench for axis_ramp_player: a cycle-level reference model predicts strobes and status.
module tb_axis_ramp_player;
    localparam int DW    = 16;
    localparam int RW    = 16;
    localparam int DEPTH = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [RW-1:0] cfg_rate = '0;
    logic [RW-1:0] cfg_len = '0;
    logic          ramp_rq = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] dac_data;
    logic          dac_strb;
    logic          busy;
    logic          underflow;
    logic [RW-1:0] sample_cnt;

    axis_ramp_player #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .RATE_WIDTH (RW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_rate      (cfg_rate),
        .cfg_len       (cfg_len),
        .ramp_rq       (ramp_rq),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .dac_data      (dac_data),
        .dac_strb      (dac_strb),
        .busy          (busy),
        .underflow     (underflow),
        .sample_cnt    (sample_cnt)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] data;
        int            cnt;
        int            due;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] m_fifo[$];
    bit            m_play, m_uf, m_alive;
    int            m_rate, m_rem, m_cnt, m_next;
    logic [DW-1:0] m_dac;

    task automatic model_reset();
        m_fifo.delete();
        sb.delete();
        m_play = 0; m_uf = 0; m_alive = 0;
        m_rate = 1; m_rem = 0; m_cnt = 0; m_next = 0;
        m_dac = '0;
    endtask

    initial begin
        int c;
        bit rdy, psh, tk, st;
        logic [DW-1:0] d;
        model_reset();
        forever begin
            @(posedge aclk or negedge aresetn);
            if (!aresetn) begin
                model_reset();
            end else begin
                c   = cyc;
                rdy = m_alive && (m_fifo.size() < DEPTH);
                psh = s_axis_tvalid && rdy;
                tk  = m_play && (c == m_next);
                st  = !m_play && ramp_rq && (cfg_len != 0);
                if (tk) begin
                    m_next = c + m_rate;
                    if (m_fifo.size() > 0) begin
                        d = m_fifo.pop_front();
                        m_dac = d;
                        m_cnt++;
                        m_rem--;
                        sb.push_back('{d, m_cnt, c + 1});
                        if (m_rem == 0) m_play = 0;
                    end else begin
                        m_uf = 1;
                    end
                end
                if (st) begin
                    m_rate = (cfg_rate == 0) ? 1 : int'(cfg_rate);
                    m_rem  = int'(cfg_len);
                    m_cnt  = 0;
                    m_uf   = 0;
                    m_play = 1;
                    m_next = c + 1;
                end
                if (psh) m_fifo.push_back(s_axis_tdata);
                m_alive = 1;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit   exp_strb;
        exp_t e;
        forever begin
            @(negedge aclk);
            while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
            exp_strb = (sb.size() > 0) && (sb[0].due == cyc);
            check("dac_strb", 32'(dac_strb), 32'(exp_strb));
            if (dac_strb && exp_strb) begin
                e = sb.pop_front();
                check("strb_data", 32'(dac_data), 32'(e.data));
                check("strb_cnt", 32'(sample_cnt), 32'(e.cnt));
            end
            check("dac_data", 32'(dac_data), 32'(m_dac));
            check("busy", 32'(busy), 32'(m_play));
            check("underflow", 32'(underflow), 32'(m_uf));
            check("sample_cnt", 32'(sample_cnt), 32'(m_cnt));
            check("tready", 32'(s_axis_tready), 32'(m_alive && (m_fifo.size() < DEPTH)));
        end
    end

    // ---------------- AXI-Stream source ----------------
    logic [DW-1:0] tx_q[$];
    bit            hs_pending = 0;
    bit            src_throttle = 0;

    initial begin
        forever begin
            @(negedge aclk);
            if (hs_pending) begin
                void'(tx_q.pop_front());
                s_axis_tvalid = 1'b0;
            end
            if (!s_axis_tvalid && tx_q.size() > 0 &&
                (!src_throttle || $urandom_range(0, 2) == 0)) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = tx_q[0];
            end
            hs_pending = s_axis_tvalid && s_axis_tready && aresetn;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_ramp(input int rate, input int len);
        @(negedge aclk);
        cfg_rate = RW'(rate);
        cfg_len  = RW'(len);
        ramp_rq  = 1'b1;
        @(negedge aclk);
        ramp_rq  = 1'b0;
        $display("ramp_rq rate=%0d len=%0d busy=%0d", rate, len, busy);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge aclk);
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ramp_timeout: busy still 1 after %0d cycles, required 0", budget);
        end
        repeat (3) @(negedge aclk);
        $display("ramp done cnt=%0d underflow=%0d last=%04h", sample_cnt, underflow, dac_data);
    endtask

    task automatic wait_src(input int budget);
        int n = 0;
        while ((tx_q.size() > 0 || s_axis_tvalid) && n < budget) begin
            @(negedge aclk);
            n++;
        end
        if (tx_q.size() > 0 || s_axis_tvalid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL src_timeout: %0d samples unsent after %0d cycles, required 0", tx_q.size(), budget);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (10) @(negedge aclk);
        #1 aresetn = 1'b1;

        // pre-fill and basic ramp
        for (int i = 1; i <= 4; i++) tx_q.push_back(DW'(i));
        wait_src(100);
        repeat (3) @(negedge aclk);
        start_ramp(5, 4);
        wait_done(200);

        // underflow: second and third samples arrive late
        tx_q.push_back(16'h0011);
        wait_src(50);
        start_ramp(3, 3);
        repeat (10) @(negedge aclk);
        tx_q.push_back(16'h0012);
        tx_q.push_back(16'h0013);
        wait_done(200);
        tx_q.push_back(16'h0021);
        wait_src(50);
        start_ramp(2, 1);
        wait_done(50);

        // backpressure: 20 samples into a 16-deep FIFO while idle
        for (int i = 0; i < 20; i++) tx_q.push_back(16'h0100 + DW'(i));
        repeat (40) @(negedge aclk);
        check("bp_unsent", 32'(tx_q.size() + (s_axis_tvalid ? 0 : 0)), 32'd4);
        start_ramp(1, 20);
        wait_done(200);

        // edge configurations
        for (int i = 0; i < 3; i++) tx_q.push_back(16'h0200 + DW'(i));
        wait_src(50);
        start_ramp(0, 3);
        wait_done(50);
        start_ramp(2, 0);
        check("len0_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) tx_q.push_back(16'h0300 + DW'(i));
        wait_src(50);
        start_ramp(4, 3);
        repeat (3) @(negedge aclk);
        start_ramp(1, 7);
        wait_done(100);
        check("no_restart_cnt", 32'(sample_cnt), 32'd3);

        // randomized ramps with a throttled source
        src_throttle = 1;
        for (int r = 0; r < 8; r++) begin
            int rate;
            int len;
            rate = $urandom_range(0, 4);
            len  = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) tx_q.push_back(DW'($urandom));
            repeat ($urandom_range(0, 5)) @(negedge aclk);
            start_ramp(rate, len);
            wait_done(2000);
        end
        src_throttle = 0;
        wait_src(100);

        // reset in the middle of a ramp
        for (int i = 0; i < 5; i++) tx_q.push_back(16'h0A1 + DW'(i));
        wait_src(50);
        start_ramp(2, 5);
        repeat (4) @(negedge aclk);
        #1 aresetn = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dac_data", 32'(dac_data), 32'd0);
        check("rst_dac_strb", 32'(dac_strb), 32'd0);
        check("rst_sample_cnt", 32'(sample_cnt), 32'd0);
        check("rst_tready", 32'(s_axis_tready), 32'd0);
        repeat (3) @(negedge aclk);
        #1 aresetn = 1'b1;
        tx_q.push_back(16'h00B1);
        tx_q.push_back(16'h00B2);
        wait_src(50);
        start_ramp(1, 2);
        wait_done(50);
        check("post_rst_last", 32'(dac_data), 32'h00B2);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_ramp_player.md
Name: axis_ramp_player

Overview:
- Downstream stage of the ramp request block.
- Consumes the 16-bit AXI-Stream ramp samples and the ramp_rq start pulse, and buffers samples in a small FIFO.
- On each ramp start, replays cfg_len samples to the DAC interface at a fixed pace: one sample every cfg_rate clock cycles.
- Flags underflow when the upstream stream cannot keep up.

Parameters:
- DATA_WIDTH, 16, sample width; matches the upstream m_axis_tdata.
- FIFO_DEPTH, 16, sample buffer depth; power of two, minimum 4.
- RATE_WIDTH, 16, width of cfg_rate and cfg_len.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- cfg_rate  in  RATE_WIDTH  output sample period in cycles; 0 is treated as 1
- cfg_len  in  RATE_WIDTH  samples per ramp
- ramp_rq  in  1  single-cycle ramp start pulse from upstream
- s_axis_tdata  in  DATA_WIDTH  ramp sample
- s_axis_tvalid  in  1  sample valid
- s_axis_tready  out  1  sample accept
- dac_data  out  DATA_WIDTH  registered DAC code; holds between strobes
- dac_strb  out  1  one-cycle pulse per new dac_data
- busy  out  1  ramp in progress
- underflow  out  1  sticky; set on an empty-FIFO tick, cleared on the next accepted ramp_rq
- sample_cnt  out  RATE_WIDTH  samples emitted in the current or last ramp

Behaviour:
- Clock and reset:
  - One clock, aclk.
  - aresetn is asynchronous and active-low.
- Reset values:
  - All outputs are 0, including s_axis_tready, which is held 0 while aresetn is low.
  - FIFO empty, state IDLE, rate counter 0, remaining 0.
- Input side:
  - s_axis_tready = !fifo_full (registered occupancy), independent of state, so pre-fill before ramp_rq is allowed.
  - Push when s_axis_tvalid && s_axis_tready.
  - Data is never dropped or duplicated.
- State IDLE:
  - ramp_rq=1 with cfg_len!=0:
    - latch rate = max(cfg_rate,1) and remaining = cfg_len;
    - clear underflow and sample_cnt;
    - load rate counter to 0;
    - go to PLAY.
    - busy rises the cycle after ramp_rq is sampled.
  - ramp_rq with cfg_len==0 is ignored; underflow is not cleared.
- State PLAY:
  - tick = (rate counter == 0). On a tick the counter reloads rate-1; otherwise it decrements.
  - tick with FIFO non-empty (registered occupancy):
    - pop;
    - dac_data <= head;
    - dac_strb=1 for exactly the next cycle;
    - sample_cnt++ and remaining--.
  - tick with FIFO empty:
    - no pop, no strobe;
    - dac_data holds;
    - underflow <= 1;
    - remaining unchanged, so the sample is retried on the next tick.
  - A push in the same cycle as an empty tick does not satisfy that tick.
  - Latency: ramp_rq sampled at edge N, FIFO non-empty → dac_strb high in the cycle after edge N+1. Successive strobes are exactly rate cycles apart while data is available.
  - When the pop that takes remaining from 1 to 0 occurs: return to IDLE; busy falls with the last dac_strb.
  - ramp_rq while busy is ignored and latched cfg is unaffected. cfg_rate and cfg_len changes mid-ramp have no effect.
- Push/pop:
  - Simultaneous push and pop are both performed; occupancy is unchanged.
  - Full FIFO: no push that cycle, even if a pop occurs.
- Wrap-around:
  - FIFO pointers wrap modulo FIFO_DEPTH; occupancy is tracked with one extra bit.
  - sample_cnt cannot exceed cfg_len, so no wrap.
- Reset mid-ramp:
  - Immediate return to the reset values above.
  - FIFO contents are discarded.

Decomposition:
- ramp_pkg holds:
  - the state type (IDLE, PLAY);
  - default DATA_WIDTH/RATE_WIDTH constants;
  - the rate-clamp function max(x,1).
- One sub-module, axis_ramp_fifo:
  - synchronous FIFO with DEPTH and WIDTH parameters;
  - push/pop, head, full, empty and count outputs;
  - same aclk/aresetn.
- The player instantiates it and contains only the control FSM and rate counter.

Test Plan:
- Reset/pre-fill: hold aresetn=0 for 10 cycles, then push 4 samples 0x0001..0x0004 → tready=0 during reset, then 1; no dac_strb while IDLE; FIFO count=4.
- Basic ramp: cfg_rate=5, cfg_len=4, pre-filled as above, pulse ramp_rq at edge N → dac_strb at N+2, N+7, N+12, N+17 with dac_data 1,2,3,4; busy low after the last strobe; underflow=0; sample_cnt=4.
- Underflow: cfg_rate=3, cfg_len=3, one sample pre-filled, second sample pushed 10 cycles late → underflow=1 after the first empty tick; all 3 samples still emitted in order; next ramp_rq clears underflow.
- Backpressure: FIFO_DEPTH=16, stream 20 samples with the ramp idle → tready drops after 16 accepts; start a ramp with cfg_rate=1 and cfg_len=20 → all 20 values emitted in order, none lost.
- Edge configuration: cfg_rate=0 gives one strobe per cycle; cfg_len=0 ramp_rq keeps busy=0; ramp_rq mid-ramp produces no restart.
- Reset mid-ramp: assert aresetn low during PLAY → outputs go to 0 asynchronously; a new ramp after release starts from an empty FIFO.
